// File: rtl/fft_unload_if.sv
// Downstream bin stream of the FFT unload block: one complex bin per valid/ready handshake.
// Sized by BIT_WIDTH (component width) and N (index width).
interface fft_unload_if #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
);
    logic [BIT_WIDTH-1:0] out_re;
    logic [BIT_WIDTH-1:0] out_im;
    logic [N-1:0]         out_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_re,
        output out_im,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_re,
        input  out_im,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_unload.sv
// Streams a finished FFT result bank out in natural bin order over a valid/ready interface.
// Optional macro UNLOAD_HALF_EN: emit only bins 0..2^(N-1)-1 (non-redundant half of a real spectrum).
module fft_unload #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic                   read_sel,
    output logic [N-1:0]           r0_add_rd,
    output logic [N-1:0]           r1_add_rd,
    input  logic [2*BIT_WIDTH-1:0] r0_data,
    input  logic [2*BIT_WIDTH-1:0] r1_data,
    fft_unload_if.master           stream,
    output logic                   busy,
    output logic                   unload_done
);

`ifdef UNLOAD_HALF_EN
    localparam logic [N-1:0] LAST = {1'b0, {(N-1){1'b1}}};
`else
    localparam logic [N-1:0] LAST = {N{1'b1}};
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [N-1:0]         cnt_r;
    logic [N-1:0]         cnt_s;
    logic [N-1:0]         cnt_inc_s;
    logic                 bank_q_r;
    logic                 bank_q_s;
    logic [N-1:0]         r0_add_r;
    logic [N-1:0]         r0_add_s;
    logic [N-1:0]         r1_add_r;
    logic [N-1:0]         r1_add_s;
    logic [BIT_WIDTH-1:0] re_r;
    logic [BIT_WIDTH-1:0] re_s;
    logic [BIT_WIDTH-1:0] im_r;
    logic [BIT_WIDTH-1:0] im_s;
    logic [N-1:0]         idx_r;
    logic [N-1:0]         idx_s;
    logic                 valid_r;
    logic                 valid_s;
    logic                 last_r;
    logic                 last_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 done_r;
    logic                 done_s;
    logic                 hs_s;
    logic [2*BIT_WIDTH-1:0] bank_data_s;

    // Handshake, next index and the data word of the latched bank.
    always_comb begin
        hs_s        = valid_r & stream.out_ready;
        cnt_inc_s   = cnt_r + N'(1);
        bank_data_s = bank_q_r ? r1_data : r0_data;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of every registered output.
    // Bank addresses are registered on entry to FETCH so the RAM sees a stable
    // address for the whole FETCH cycle; the result is captured entering PRESENT.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        bank_q_s = bank_q_r;
        r0_add_s = {N{1'b0}};
        r1_add_s = {N{1'b0}};
        re_s     = re_r;
        im_s     = im_r;
        idx_s    = idx_r;
        valid_s  = valid_r;
        last_s   = last_r;
        case (state_r)
            IDLE: begin
                if (fft_done) begin
                    state_s  = FETCH;
                    cnt_s    = {N{1'b0}};
                    bank_q_s = read_sel;
                end else begin
                    state_s  = IDLE;
                end
            end
            FETCH: begin
                state_s = PRESENT;
                re_s    = bank_data_s[2*BIT_WIDTH-1:BIT_WIDTH];
                im_s    = bank_data_s[BIT_WIDTH-1:0];
                idx_s   = cnt_r;
                valid_s = 1'b1;
                last_s  = (cnt_r == LAST);
            end
            PRESENT: begin
                if (hs_s) begin
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    if (last_r) begin
                        state_s = FINISH;
                    end else begin
                        state_s = FETCH;
                        cnt_s   = cnt_inc_s;
                        if (bank_q_r) begin
                            r1_add_s = cnt_inc_s;
                        end else begin
                            r0_add_s = cnt_inc_s;
                        end
                    end
                end else begin
                    state_s = PRESENT;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == FINISH);
    end

    // Output, address and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {N{1'b0}};
            bank_q_r <= 1'b0;
            r0_add_r <= {N{1'b0}};
            r1_add_r <= {N{1'b0}};
            re_r     <= {BIT_WIDTH{1'b0}};
            im_r     <= {BIT_WIDTH{1'b0}};
            idx_r    <= {N{1'b0}};
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            bank_q_r <= bank_q_s;
            r0_add_r <= r0_add_s;
            r1_add_r <= r1_add_s;
            re_r     <= re_s;
            im_r     <= im_s;
            idx_r    <= idx_s;
            valid_r  <= valid_s;
            last_r   <= last_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign r0_add_rd        = r0_add_r;
    assign r1_add_rd        = r1_add_r;
    assign stream.out_re    = re_r;
    assign stream.out_im    = im_r;
    assign stream.out_idx   = idx_r;
    assign stream.out_valid = valid_r;
    assign stream.out_last  = last_r;
    assign busy             = busy_r;
    assign unload_done      = done_r;

endmodule
